// File: rtl/ss_pkg.sv
// Shared definitions for the signed stochastic datapath:
// decoder state encoding, result-width helper and sign-bit constants.
package ss_pkg;

    // Decoder control states
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } ss_state_t;

    // Stochastic sign encoding carried on SIGN_IN
    localparam logic SS_POS = 1'b0;
    localparam logic SS_NEG = 1'b1;

    // Width needed to hold -2^window_bits .. +2^window_bits:
    // magnitude bits for 2^window_bits, plus one sign bit.
    function automatic int unsigned ss_out_w(input int unsigned window_bits);
        int unsigned span;
        span = (32'd1 << window_bits) + 32'd1;
        return $clog2(span) + 1;
    endfunction

endpackage

// File: rtl/ss_window_counter.sv
// Sample counter for one decode window: synchronous clear, EN-qualified
// increment, wraps naturally at 2^WINDOW_BITS. terminal flags the EN cycle
// that carries the last sample of the window.
module ss_window_counter
    import ss_pkg::*;
#(
    parameter int unsigned WINDOW_BITS = 4
) (
    input  logic clk,
    input  logic init,
    input  logic clear,
    input  logic en,
    output logic terminal
);

    logic [WINDOW_BITS-1:0] count;

    // Count qualified samples; reset and clear take priority over counting
    always_ff @(posedge clk) begin
        if (init || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Last sample of the window is being presented this cycle
    always_comb begin
        terminal = en && (count == '1);
    end

endmodule

// File: rtl/ss_signed_decoder.sv
// Signed stochastic-to-binary decoder. Integrates a sign-magnitude
// stochastic stream over 2^WINDOW_BITS qualified samples and presents the
// signed count on a VALID/READY handshake, with a sticky OVERRUN flag.
// Build option SS_DEC_SIGNMAG_EN: VALUE is sign-magnitude instead of
// two's complement.
module ss_signed_decoder
    import ss_pkg::*;
#(
    parameter int unsigned WINDOW_BITS = 4,
    parameter int unsigned OUT_W       = ss_out_w(WINDOW_BITS)
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             START,
    input  logic             CONTINUOUS,
    input  logic             EN,
    input  logic             IN,
    input  logic             SIGN_IN,
    output logic [OUT_W-1:0] VALUE,
    output logic             VALID,
    input  logic             READY,
    output logic             BUSY,
    output logic             OVERRUN
);

    ss_state_t               state_q, state_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] delta, sum;
    logic [OUT_W-1:0]        value_q, value_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    cnt_clear, cnt_en, terminal;

    // Output encoding of a completed sum
`ifdef SS_DEC_SIGNMAG_EN
    function automatic logic [OUT_W-1:0] encode(input logic signed [OUT_W-1:0] v);
        logic [OUT_W-1:0] mag;
        // |v| never exceeds 2^WINDOW_BITS, so the magnitude MSB is always
        // clear and the sign can be ORed in; zero stays +0.
        mag = v[OUT_W-1] ? OUT_W'(-v) : OUT_W'(v);
        return mag | {v[OUT_W-1], {(OUT_W-1){1'b0}}};
    endfunction
`else
    function automatic logic [OUT_W-1:0] encode(input logic signed [OUT_W-1:0] v);
        return OUT_W'(v);
    endfunction
`endif

    ss_window_counter #(
        .WINDOW_BITS (WINDOW_BITS)
    ) u_window_counter (
        .clk      (CLK),
        .init     (INIT),
        .clear    (cnt_clear),
        .en       (cnt_en),
        .terminal (terminal)
    );

    // Signed contribution of the current sample; SIGN_IN ignored when IN=0
    always_comb begin
        delta = '0;
        if (IN) begin
            delta = (SIGN_IN == SS_NEG) ? '1 : {{(OUT_W-1){1'b0}}, 1'b1};
        end
        sum    = acc_q + delta;
        cnt_en = EN && (state_q == ACCUM);
    end

    // Next-state, accumulator and handshake logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        value_d   = value_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        cnt_clear = 1'b0;

        if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d   = ACCUM;
                    acc_d     = '0;
                    cnt_clear = 1'b1;
                end
            end
            ACCUM: begin
                if (EN) begin
                    acc_d = sum;
                end
                if (terminal) begin
                    value_d = encode(sum);
                    valid_d = 1'b1;
                    if (valid_q && !READY) begin
                        overrun_d = 1'b1;
                    end
                    acc_d   = '0;
                    state_d = CONTINUOUS ? ACCUM : IDLE;
                end
                // Restart wins over end-of-window state choice, but the
                // completed result above has already been captured.
                if (START) begin
                    state_d   = ACCUM;
                    acc_d     = '0;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Registered outputs
    always_comb begin
        VALUE   = value_q;
        VALID   = valid_q;
        BUSY    = (state_q == ACCUM);
        OVERRUN = overrun_q;
    end

endmodule

// File: tb/tb_ss_signed_decoder.sv
// Self-checking bench for ss_signed_decoder (WINDOW_BITS=4, OUT_W=6).
module tb_ss_signed_decoder;

    localparam int WB = 4;
    localparam int OW = 6;
    localparam int WIN = 16;

    logic          CLK = 1'b0;
    logic          INIT, START, CONTINUOUS, EN, IN, SIGN_IN, READY;
    logic [OW-1:0] VALUE;
    logic          VALID, BUSY, OVERRUN;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    ss_signed_decoder #(
        .WINDOW_BITS (WB),
        .OUT_W       (OW)
    ) dut (
        .CLK        (CLK),
        .INIT       (INIT),
        .START      (START),
        .CONTINUOUS (CONTINUOUS),
        .EN         (EN),
        .IN         (IN),
        .SIGN_IN    (SIGN_IN),
        .VALUE      (VALUE),
        .VALID      (VALID),
        .READY      (READY),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN)
    );

    typedef struct {
        string       name;
        logic [15:0] mag;
        logic [15:0] sgn;
        int          expv;
    } vec_t;

    vec_t vt[5];

    function automatic logic [OW-1:0] enc(input int v);
        logic [OW-1:0] r;
`ifdef SS_DEC_SIGNMAG_EN
        r = (v < 0) ? (OW'(-v) | 6'b100000) : OW'(v);
`else
        r = OW'(v);
`endif
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_init();
        INIT = 1'b1;
        step();
        INIT = 1'b0;
    endtask

    task automatic start_pulse();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic sample(input logic en, input logic in, input logic sg);
        EN = en; IN = in; SIGN_IN = sg;
        step();
        EN = 1'b0; IN = 1'b0; SIGN_IN = 1'b0;
    endtask

    // Reference model state for the random phase
    int  win_cnt, win_sum, m_value;
    bit  m_valid, m_ovr;

    initial begin
        INIT = 1'b0; START = 1'b0; CONTINUOUS = 1'b0; EN = 1'b0;
        IN = 1'b0; SIGN_IN = 1'b0; READY = 1'b0;

        vt[0] = '{"all_pos",   16'hFFFF, 16'h0000,  16};
        vt[1] = '{"alternate", 16'hFFFF, 16'hAAAA,   0};
        vt[2] = '{"neg12",     16'h0FFF, 16'hFFFF, -12};
        vt[3] = '{"all_neg",   16'hFFFF, 16'hFFFF, -16};
        vt[4] = '{"mixed",     16'h00FF, 16'h0003,   4};

        // Reset state
        do_init();
        check("rst_value",   int'(VALUE),   0);
        check("rst_valid",   int'(VALID),   0);
        check("rst_busy",    int'(BUSY),    0);
        check("rst_overrun", int'(OVERRUN), 0);

        // Table-driven single windows
        READY = 1'b1;
        for (int v = 0; v < 5; v++) begin
            do_init();
            start_pulse();
            check({vt[v].name, "_busy"}, int'(BUSY), 1);
            for (int i = 0; i < WIN; i++) begin
                sample(1'b1, vt[v].mag[i], vt[v].sgn[i]);
                if (i < WIN - 1) check({vt[v].name, "_early"}, int'(VALID), 0);
            end
            check({vt[v].name, "_valid"}, int'(VALID), 1);
            check({vt[v].name, "_value"}, int'(VALUE), int'(enc(vt[v].expv)));
            check({vt[v].name, "_idle"},  int'(BUSY), 0);
            step();
            check({vt[v].name, "_vdrop"}, int'(VALID), 0);
        end

        // EN stalls: 24 cycles, 16 of them qualified
        do_init();
        start_pulse();
        for (int k = 0; k < 24; k++) begin
            sample((k % 3) != 0, 1'b1, 1'b0);
            if (k < 23) check("stall_early", int'(VALID), 0);
        end
        check("stall_valid", int'(VALID), 1);
        check("stall_value", int'(VALUE), int'(enc(16)));

        // Continuous mode with stalled consumer
        do_init();
        CONTINUOUS = 1'b1;
        READY = 1'b0;
        start_pulse();
        for (int i = 0; i < 2 * WIN; i++) begin
            sample(1'b1, 1'b1, 1'b0);
            if (i == WIN - 1) begin
                check("ovr_w1_valid", int'(VALID), 1);
                check("ovr_w1_flag",  int'(OVERRUN), 0);
            end
        end
        check("ovr_w2_flag",  int'(OVERRUN), 1);
        check("ovr_w2_valid", int'(VALID), 1);
        check("ovr_w2_value", int'(VALUE), int'(enc(16)));
        READY = 1'b1;
        step();
        check("ovr_drain_valid", int'(VALID), 0);
        check("ovr_drain_flag",  int'(OVERRUN), 1);
        check("ovr_busy",        int'(BUSY), 1);

        // INIT mid-window, then a clean window
        READY = 1'b0;
        for (int i = 0; i < 7; i++) sample(1'b1, 1'b1, 1'b0);
        do_init();
        check("abort_valid",   int'(VALID), 0);
        check("abort_busy",    int'(BUSY), 0);
        check("abort_overrun", int'(OVERRUN), 0);
        CONTINUOUS = 1'b0;
        READY = 1'b1;
        start_pulse();
        for (int i = 0; i < WIN; i++) sample(1'b1, 1'b1, 1'b1);
        check("abort_next_valid", int'(VALID), 1);
        check("abort_next_value", int'(VALUE), int'(enc(-16)));

        // Restart at sample 10: partial sum discarded
        do_init();
        start_pulse();
        for (int i = 0; i < 9; i++) sample(1'b1, 1'b1, 1'b0);
        START = 1'b1;
        sample(1'b1, 1'b1, 1'b0);
        START = 1'b0;
        check("restart_busy", int'(BUSY), 1);
        for (int i = 0; i < WIN; i++) begin
            sample(1'b1, i < 12, 1'b1);
            if (i < WIN - 1) check("restart_early", int'(VALID), 0);
        end
        check("restart_valid", int'(VALID), 1);
        check("restart_value", int'(VALUE), int'(enc(-12)));

        // Randomized continuous run against window-sum model
        do_init();
        CONTINUOUS = 1'b1;
        READY = 1'b0;
        start_pulse();
        win_cnt = 0; win_sum = 0; m_value = 0; m_valid = 0; m_ovr = 0;
        for (int c = 0; c < 600; c++) begin
            EN      = ($urandom_range(0, 3) != 0);
            IN      = $urandom_range(0, 1) == 1;
            SIGN_IN = $urandom_range(0, 1) == 1;
            READY   = ($urandom_range(0, 3) == 0);
            step();
            if (EN) begin
                win_sum += IN ? (SIGN_IN ? -1 : 1) : 0;
                win_cnt++;
            end
            if (win_cnt == WIN) begin
                if (m_valid && !READY) m_ovr = 1;
                m_valid = 1;
                m_value = win_sum;
                win_cnt = 0;
                win_sum = 0;
            end else if (m_valid && READY) begin
                m_valid = 0;
            end
            check("rnd_valid",   int'(VALID),   int'(m_valid));
            check("rnd_overrun", int'(OVERRUN), int'(m_ovr));
            if (m_valid) check("rnd_value", int'(VALUE), int'(enc(m_value)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ss_signed_decoder.md
# ss_signed_decoder

Signed stochastic-to-binary decoder: the reader at the output end of the signed stochastic datapath. It consumes a sign-magnitude stochastic bitstream (data bit plus sign bit, as produced by the signed add/sub stage). Over a window of 2^WINDOW_BITS valid samples it integrates the stream into a signed binary count, then presents the result on a valid/ready handshake. It sits between the stochastic neuron layers and the binary readout/host logic.

## Interface
- WINDOW_BITS, 4: log2 of samples per window (window = 16 at default).
- OUT_W, WINDOW_BITS+2: result width; must hold −2^WINDOW_BITS..+2^WINDOW_BITS.
- CLK  in  1  clock, all logic on rising edge.
- INIT  in  1  reset; one clock; reset is synchronous and active-high.
- START  in  1  begin a window (from IDLE) or restart the current window (from ACCUM).
- CONTINUOUS  in  1  1: start the next window immediately after each window ends; 0: return to IDLE.
- EN  in  1  sample qualifier; IN/SIGN_IN counted only when EN=1.
- IN  in  1  stochastic magnitude bit.
- SIGN_IN  in  1  sign of IN (1 = negative).
- VALUE  out  OUT_W  decoded result; two's complement by default.
- VALID  out  1  VALUE holds an unconsumed result.
- READY  in  1  consumer accepts VALUE when VALID&READY.
- BUSY  out  1  state is ACCUM.
- OVERRUN  out  1  sticky: a result was overwritten before it was accepted.

## Operation
- States: IDLE, ACCUM.
- IDLE → ACCUM on START. Accumulator and sample counter clear on entry.
- ACCUM, per EN=1 cycle:
  - IN=1, SIGN_IN=0: add +1.
  - IN=1, SIGN_IN=1: add −1.
  - IN=0: add 0; SIGN_IN is ignored.
- The sample counter is WINDOW_BITS wide and wraps. The window ends on the EN=1 cycle when the counter equals 2^WINDOW_BITS−1.
- At window end:
  - VALUE loads the final sum, including that last sample.
  - VALID is set.
  - Accumulator clears.
  - Next state is ACCUM if CONTINUOUS=1, else IDLE.
- START in ACCUM: clears accumulator and counter and restarts the window. Any in-progress partial sum is discarded. If START coincides with window end, the result still loads and the restart applies.
- Handshake: VALID&READY clears VALID on the next edge.
  - If a new result loads on the same edge, VALID stays 1 and OVERRUN is not set.
  - If a new result loads while VALID=1 and READY=0, VALUE is overwritten, VALID stays 1 and OVERRUN sets.
  - OVERRUN clears only on INIT.
- VALUE is stable while VALID=1 except on overrun.
- Arithmetic: the accumulator is OUT_W signed. It never saturates because its range is sized exactly.

## Timing
- All outputs reset to 0 on INIT; state resets to IDLE.
- INIT mid-window discards the partial sum and any pending VALID.
- First counted sample: the first EN=1 cycle after the START edge.
- Latency: VALID and VALUE are visible one cycle after the last sample's edge (registered).
- BUSY is high from the cycle after START until the cycle after window end (CONTINUOUS=0).
- EN=0 cycles stall counting with no effect on state.

## Configuration
- SS_DEC_SIGNMAG_EN defined:
  - VALUE is sign-magnitude: MSB is the sign, the low OUT_W−1 bits are the magnitude. This matches the stochastic sign convention.
  - Zero is always +0 (MSB=0).
- Undefined: VALUE is two's complement.

## Structure
- Shared package ss_pkg holds:
  - the state enum (IDLE, ACCUM);
  - the result-width function clog2-based OUT_W helper;
  - the SS sign encoding constants (POS=0, NEG=1).
- Sub-module ss_window_counter holds the WINDOW_BITS sample counter: clear, EN increment, terminal-count output. The top level instantiates it once.

## Test plan
All cases use WINDOW_BITS=4.
- START, 16 cycles EN=1 IN=1 SIGN_IN=0, READY=1 → VALUE=+16 (6'b010000), VALID for one cycle, one cycle after the 16th sample.
- 16 samples alternating +1/−1 → VALUE=0. 12 samples IN=1 SIGN_IN=1 followed by 4 samples IN=0 → VALUE=−12 (6'b110100); with SS_DEC_SIGNMAG_EN, VALUE=6'b101100.
- 16 EN=1 samples interleaved with 8 EN=0 cycles holding IN=1 → VALUE=+16; VALID asserts after the 24th active cycle, not earlier.
- CONTINUOUS=1, READY=0, all +1 samples → after window 2, OVERRUN=1, VALID=1, VALUE=+16. Then raise READY → VALID clears next edge and OVERRUN stays 1.
- INIT after 7 counted samples → VALID=0, BUSY=0, OVERRUN=0 on the next edge. Then START + 16 samples of −1 → VALUE=−16 (6'b110000), with no carry-over from the aborted window.
- START pulsed at sample 10 of a window → no result from that window; the next result appears 16 EN cycles after the restart.
